ahblite_slave_mux_n: RTL and testbench
======================================

# ahblite_slave_mux_n

Parametrised AHB-Lite data-phase response multiplexer for the SoC bus matrix, selecting HREADYOUT/HRESP/HRDATA from one of NUM_PORTS slaves. It sits between the address decoder and the Cortex-M0 master. Beyond plain muxing, it contains a built-in default slave that returns a two-cycle AHB ERROR for unmapped or multiply-decoded active transfers. An optional watchdog aborts slaves that stall the bus too long.

## Interface
Parameters:
- NUM_PORTS, 5: number of slave ports, 1..16.
- DATA_W, 32: HRDATA width.
- TIMEOUT_CYCLES, 256: consecutive wait-state limit before abort, at least 2. Only used with AHB_MUX_TIMEOUT_EN.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  asynchronous, active-high reset.
- HREADY  in  1  system HREADY (this block's HREADYOUT fed back); qualifies address phase.
- HTRANS  in  2  master transfer type; only bit 1 (active transfer) is used.
- P_HSEL  in  NUM_PORTS  decoder selects, bit i = port i.
- P_HREADYOUT  in  NUM_PORTS  slave ready, bit i = port i.
- P_HRESP  in  NUM_PORTS  slave response, bit i = port i.
- P_HRDATA  in  NUM_PORTS*DATA_W  slave read data, port i at [i*DATA_W +: DATA_W].
- HREADYOUT  out  1  muxed ready to master.
- HRESP  out  1  muxed response to master.
- HRDATA  out  DATA_W  muxed read data.
- P_ABORT  out  NUM_PORTS  one-cycle abort pulse to a timed-out slave (timeout build only; tied 0 otherwise).
- TIMEOUT_FLAG  out  1  sticky timeout status (timeout build only).
- TIMEOUT_PORT  out  4  index of last timed-out port (timeout build only).
- TIMEOUT_CLR  in  1  clears TIMEOUT_FLAG.

## Operation
- Address-phase capture happens when HREADY=1:
  - sel_q ← P_HSEL.
  - act_q ← HTRANS[1].
  - Decode class: NONE (no bits set), ONE, or MULTI (more than one bit set).
- FSM states: IDLE, DATA, ERR1, ERR2, TERR1, TERR2.
- Transitions when HREADY=1:
  - To DATA if class ONE.
  - To ERR1 if act_q=1 and class is NONE or MULTI.
  - Otherwise to IDLE.
- IDLE: HREADYOUT=1, HRESP=0, HRDATA=0 (zero-wait OKAY for IDLE/BUSY or unselected transfers).
- DATA: outputs follow port sel_q exactly (ready, response, data).
- ERR1: HREADYOUT=0, HRESP=1. Next state is ERR2.
- ERR2: HREADYOUT=1, HRESP=1. The new address phase is captured in this cycle.
- TERR1 / TERR2: same response as ERR1 / ERR2, but entered via timeout.
  - In TERR1, P_ABORT[sel_q]=1.
  - On entry to TERR1, sel_q is cleared so the stalled slave's later outputs are ignored.
- HRDATA is 0 in every state except DATA.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Increments each DATA cycle with the selected HREADYOUT=0.
  - Clears on any cycle with HREADYOUT=1 and on leaving DATA.
- Timeout trigger: counter reaches TIMEOUT_CYCLES.
  - Next state is TERR1.
  - TIMEOUT_FLAG ← 1, TIMEOUT_PORT ← index of sel_q.
- TIMEOUT_CLR and a new timeout in the same cycle: set wins.
- A slave asserting its own ERROR in DATA is passed through unchanged; the mux does not interfere.

## Timing
- Output mux is combinational from registered sel_q/state; zero added latency in DATA.
- Default-slave error takes exactly 2 cycles: 0/1 then 1/1 on HREADYOUT/HRESP.
- Timeout: with the slave stalled from the first data cycle, TERR1 is the cycle after TIMEOUT_CYCLES stall cycles; TERR2 follows.
- Reset (HRESET=1, asynchronous):
  - State IDLE, sel_q=0, act_q=0, counter 0.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - P_ABORT=0, TIMEOUT_FLAG=0, TIMEOUT_PORT=0.
- Reset mid-ERR or mid-DATA: immediate return to reset values; no pending error survives.

## Configuration
- AHB_MUX_TIMEOUT_EN defined: watchdog counter, TERR1/TERR2 states, P_ABORT, TIMEOUT_FLAG and TIMEOUT_PORT are all implemented.
- Not defined:
  - No counter and no TERR states; DATA waits indefinitely.
  - P_ABORT=0, TIMEOUT_FLAG=0, TIMEOUT_PORT=0, TIMEOUT_CLR ignored.

## Test plan
- Reset then idle bus: HREADYOUT=1, HRESP=0, HRDATA=0 throughout.
- NONSEQ to port 3 with 2 wait states, read data 0xA5A5_0003: two cycles of HREADYOUT=0, then HREADYOUT=1, HRDATA=0xA5A5_0003, HRESP=0.
- NONSEQ with P_HSEL=0, then a second case with P_HSEL=5'b00110: each gives HREADYOUT/HRESP = 0/1 then 1/1, HRDATA=0. The same P_HSEL values with HTRANS=IDLE give a zero-wait OKAY.
- Back-to-back transfers port 0 → unmapped → port 4: correct per-phase data and the error sequence, with no lost address phase in ERR2.
- Timeout build, TIMEOUT_CYCLES=4, port 2 holds HREADYOUT=0:
  - TERR1 on cycle 5 of the data phase, with P_ABORT=5'b00100 for one cycle.
  - TIMEOUT_FLAG=1, TIMEOUT_PORT=2.
  - TIMEOUT_CLR asserted on a later cycle clears the flag.
  - TIMEOUT_CLR asserted in the same cycle as a new timeout leaves the flag at 1.
- Assert HRESET during ERR1: outputs return to 1/0/0 immediately, and the next transfer to port 1 completes OKAY.

Source files
------------

// File: rtl/ahblite_slave_mux_n.sv
// -----------------------------------------------------------------------------
// ahblite_slave_mux_n
//
// AHB-Lite data-phase response multiplexer with a built-in default slave.
// The decoder's P_HSEL is captured in the address phase (HREADY=1). In the
// data phase the selected slave's HREADYOUT/HRESP/HRDATA are forwarded to the
// master. Active transfers that decode to no slave, or to more than one slave,
// get a two-cycle ERROR from the default slave.
//
// Optional watchdog (define AHB_MUX_TIMEOUT_EN): a slave that holds
// HREADYOUT low for TIMEOUT_CYCLES consecutive data-phase cycles is abandoned.
// It gets a one-cycle P_ABORT pulse and the master gets a two-cycle ERROR.
//
// Ports
//   HCLK, HRESET      bus clock, asynchronous active-high reset
//   HREADY            system HREADY (this block's HREADYOUT fed back)
//   HTRANS            master transfer type (bit 1 = active transfer)
//   P_HSEL            decoder selects, one bit per slave port
//   P_HREADYOUT       per-port slave ready
//   P_HRESP           per-port slave response
//   P_HRDATA          per-port read data, port i at [i*DATA_W +: DATA_W]
//   HREADYOUT/HRESP/HRDATA   muxed response to the master
//   P_ABORT           one-cycle abort pulse to a timed-out slave
//   TIMEOUT_FLAG      sticky timeout status, cleared by TIMEOUT_CLR
//   TIMEOUT_PORT      index of the last timed-out port
//   TIMEOUT_CLR       clears TIMEOUT_FLAG (a timeout in the same cycle wins)
//   dbg_state         current FSM state, for observation only
//
// Valid/ready: an address phase is accepted on every rising HCLK edge where
// HREADY=1; a data phase completes on the edge where HREADYOUT=1.
// -----------------------------------------------------------------------------
module ahblite_slave_mux_n #(
    parameter int NUM_PORTS      = 5,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic                        HREADY,
    input  logic [1:0]                  HTRANS,
    input  logic [NUM_PORTS-1:0]        P_HSEL,
    input  logic [NUM_PORTS-1:0]        P_HREADYOUT,
    input  logic [NUM_PORTS-1:0]        P_HRESP,
    input  logic [NUM_PORTS*DATA_W-1:0] P_HRDATA,
    output logic                        HREADYOUT,
    output logic                        HRESP,
    output logic [DATA_W-1:0]           HRDATA,
    output logic [NUM_PORTS-1:0]        P_ABORT,
    output logic                        TIMEOUT_FLAG,
    output logic [3:0]                  TIMEOUT_PORT,
    input  logic                        TIMEOUT_CLR,
    output logic [2:0]                  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_ERR1  = 3'd2,
        ST_ERR2  = 3'd3,
        ST_TERR1 = 3'd4,
        ST_TERR2 = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   sel_q;
    logic                   act_q;
    logic                   capture;
    logic                   trigger;

    // Decode class of the address-phase selects.
    logic hsel_none;
    logic hsel_one;
    assign hsel_none = (P_HSEL == '0);
    // Clearing the lowest set bit leaves zero only for a single set bit.
    assign hsel_one  = !hsel_none && ((P_HSEL & (P_HSEL - NUM_PORTS'(1))) == '0);

    // AND-OR mux over the registered one-hot select.
    logic              slv_rdy;
    logic              slv_rsp;
    logic [DATA_W-1:0] slv_dat;
    always_comb begin
        slv_rdy = 1'b0;
        slv_rsp = 1'b0;
        slv_dat = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_q[i]) begin
                slv_rdy = slv_rdy | P_HREADYOUT[i];
                slv_rsp = slv_rsp | P_HRESP[i];
                slv_dat = slv_dat | P_HRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next state. An address phase is taken whenever HREADY is high, except
    // in the first cycle of an error response (HREADYOUT is low there anyway)
    // and on a watchdog abort.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR2, ST_TERR2: begin
                if (HREADY) capture = 1'b1;
            end
            ST_DATA: begin
                if (trigger)     state_d = ST_TERR1;
                else if (HREADY) capture = 1'b1;
            end
            ST_ERR1:  state_d = ST_ERR2;
            ST_TERR1: state_d = ST_TERR2;
            default:  state_d = ST_IDLE;
        endcase
        if (capture) begin
            if (hsel_one)       state_d = ST_DATA;
            else if (HTRANS[1]) state_d = ST_ERR1;
            else                state_d = ST_IDLE;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (trigger) begin
                // Forget the stalled slave so its late outputs are ignored.
                sel_q <= '0;
            end else if (capture) begin
                sel_q <= P_HSEL;
                act_q <= HTRANS[1];
            end
        end
    end

    // Response outputs. HRDATA is only non-zero while a real slave is selected.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        case (state_q)
            ST_DATA: begin
                HREADYOUT = slv_rdy;
                HRESP     = slv_rsp;
                HRDATA    = slv_dat;
            end
            ST_ERR1, ST_TERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2, ST_TERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_state = state_q;

`ifdef AHB_MUX_TIMEOUT_EN
    localparam int                CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0]        cnt_q;
    logic                 stall;
    logic [3:0]           sel_idx;
    logic [NUM_PORTS-1:0] abort_q;
    logic                 flag_q;
    logic [3:0]           port_q;

    assign stall = (state_q == ST_DATA) && !slv_rdy;
    // Firing one count early makes TERR1 the cycle right after the
    // TIMEOUT_CYCLES-th stalled cycle.
    assign trigger = stall && (cnt_q == CNT_LAST);

    always_comb begin
        sel_idx = 4'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_q[i]) sel_idx = 4'(i);
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cnt_q   <= '0;
            abort_q <= '0;
            flag_q  <= 1'b0;
            port_q  <= 4'd0;
        end else begin
            if (stall && !trigger) cnt_q <= cnt_q + CW'(1);
            else                   cnt_q <= '0;
            // Registered abort lines up exactly with the TERR1 cycle.
            abort_q <= trigger ? sel_q : '0;
            if (trigger) begin
                flag_q <= 1'b1;
                port_q <= sel_idx;
            end else if (TIMEOUT_CLR) begin
                flag_q <= 1'b0;
            end
        end
    end

    assign P_ABORT      = abort_q;
    assign TIMEOUT_FLAG = flag_q;
    assign TIMEOUT_PORT = port_q;

    logic unused_sink;
    assign unused_sink = ^{HTRANS[0], act_q};
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign trigger      = 1'b0;
    assign P_ABORT      = '0;
    assign TIMEOUT_FLAG = 1'b0;
    assign TIMEOUT_PORT = 4'd0;

    logic unused_sink;
    assign unused_sink = ^{HTRANS[0], act_q, TIMEOUT_CLR};
`endif

endmodule

// File: tb/tb_ahblite_slave_mux_n.sv
// -----------------------------------------------------------------------------
// tb_ahblite_slave_mux_n
//
// Bench for ahblite_slave_mux_n. The slaves are modelled by the bench itself.
// Every transfer is turned into its list of expected data-phase beats
// (ready/resp/data/abort) from the bus rules. Each beat is compared with the
// DUT outputs once per cycle.
// -----------------------------------------------------------------------------
module tb_ahblite_slave_mux_n;

  localparam int NP = 5;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef AHB_MUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  // ---------------- DUT signals ----------------
  logic              HREADY;
  logic [1:0]        HTRANS = 2'b00;
  logic [NP-1:0]     P_HSEL = '0;
  logic [NP-1:0]     P_HREADYOUT = '1;
  logic [NP-1:0]     P_HRESP = '0;
  logic [NP*DW-1:0]  P_HRDATA = '0;
  logic              HREADYOUT;
  logic              HRESP;
  logic [DW-1:0]     HRDATA;
  logic [NP-1:0]     P_ABORT;
  logic              TIMEOUT_FLAG;
  logic [3:0]        TIMEOUT_PORT;
  logic              TIMEOUT_CLR = 1'b0;
  logic [2:0]        dbg_state;

  assign HREADY = HREADYOUT;

  ahblite_slave_mux_n #(
    .NUM_PORTS      (NP),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HREADY       (HREADY),
    .HTRANS       (HTRANS),
    .P_HSEL       (P_HSEL),
    .P_HREADYOUT  (P_HREADYOUT),
    .P_HRESP      (P_HRESP),
    .P_HRDATA     (P_HRDATA),
    .HREADYOUT    (HREADYOUT),
    .HRESP        (HRESP),
    .HRDATA       (HRDATA),
    .P_ABORT      (P_ABORT),
    .TIMEOUT_FLAG (TIMEOUT_FLAG),
    .TIMEOUT_PORT (TIMEOUT_PORT),
    .TIMEOUT_CLR  (TIMEOUT_CLR),
    .dbg_state    (dbg_state)
  );

  // ---------------- transfer and beat records ----------------
  typedef struct packed {
    logic [NP-1:0] hsel;
    logic [1:0]    trans;
    logic [7:0]    waits;   // slave wait states before ready
    logic          serr;    // slave drives HRESP=1 for the whole data phase
    logic          clr_all; // hold TIMEOUT_CLR high during this data phase
    logic [DW-1:0] data;
  } xfer_t;

  typedef struct packed {
    logic          terr1;
    logic [NP-1:0] abrt;
    logic          rdy;
    logic          rsp;
    logic [DW-1:0] dat;
  } beat_t;

  localparam int BW = $bits(beat_t);

  logic [BW-1:0] exp_q[$];
  xfer_t         plan_q[$];
  xfer_t         cur;
  xfer_t         nxt;
  int            dcnt;
  logic          m_flag;
  logic [3:0]    m_port;
  logic          clr_prev;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit is_onehot(input logic [NP-1:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic logic [3:0] port_of(input logic [NP-1:0] v);
    logic [3:0] p;
    p = 4'd0;
    for (int i = 0; i < NP; i++) if (v[i]) p = 4'(i);
    return p;
  endfunction

  function automatic logic [BW-1:0] mk_beat(input logic t1, input logic [NP-1:0] ab,
                                            input logic rdy, input logic rsp,
                                            input logic [DW-1:0] dat);
    beat_t b;
    b.terr1 = t1;
    b.abrt  = ab;
    b.rdy   = rdy;
    b.rsp   = rsp;
    b.dat   = dat;
    return BW'(b);
  endfunction

  function automatic xfer_t mk_xfer(input logic [NP-1:0] hsel, input logic [1:0] trans,
                                    input int waits, input logic serr, input logic clr_all,
                                    input logic [DW-1:0] data);
    xfer_t x;
    x.hsel    = hsel;
    x.trans   = trans;
    x.waits   = 8'(waits);
    x.serr    = serr;
    x.clr_all = clr_all;
    x.data    = data;
    return x;
  endfunction

  // Reference model: the response a transfer should get, beat by beat.
  task automatic push_beats(input xfer_t x);
    if (is_onehot(x.hsel)) begin
      if (TO_EN && (int'(x.waits) >= TO)) begin
        for (int i = 0; i < TO; i++) exp_q.push_back(mk_beat(1'b0, '0, 1'b0, x.serr, x.data));
        exp_q.push_back(mk_beat(1'b1, x.hsel, 1'b0, 1'b1, '0));
        exp_q.push_back(mk_beat(1'b0, '0, 1'b1, 1'b1, '0));
      end else begin
        for (int i = 0; i < int'(x.waits); i++) exp_q.push_back(mk_beat(1'b0, '0, 1'b0, x.serr, x.data));
        exp_q.push_back(mk_beat(1'b0, '0, 1'b1, x.serr, x.data));
      end
    end else if (x.trans[1]) begin
      exp_q.push_back(mk_beat(1'b0, '0, 1'b0, 1'b1, '0));
      exp_q.push_back(mk_beat(1'b0, '0, 1'b1, 1'b1, '0));
    end else begin
      exp_q.push_back(mk_beat(1'b0, '0, 1'b1, 1'b0, '0));
    end
  endtask

  function automatic xfer_t gen_xfer();
    xfer_t x;
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 60)      x.hsel = NP'(1 << $urandom_range(0, NP-1));
    else if (r < 75) x.hsel = '0;
    else             x.hsel = NP'($urandom_range(0, (1 << NP) - 1));
    x.trans = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 99) < 70) x.trans[1] = 1'b1;
    x.waits   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 7)) : 8'($urandom_range(0, 3));
    x.serr    = ($urandom_range(0, 9) == 0);
    x.clr_all = 1'b0;
    x.data    = $urandom;
    if (!x.trans[1] && is_onehot(x.hsel)) begin
      x.waits = 8'd0;
      x.serr  = 1'b0;
    end
    return x;
  endfunction

  function automatic xfer_t next_xfer();
    if (plan_q.size() != 0) return plan_q.pop_front();
    return gen_xfer();
  endfunction

  task automatic model_init();
    exp_q.delete();
    cur      = mk_xfer('0, 2'b00, 0, 1'b0, 1'b0, '0);
    push_beats(cur);
    nxt      = next_xfer();
    dcnt     = 0;
    m_flag   = 1'b0;
    m_port   = 4'd0;
    clr_prev = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic run_cycles(input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      @(posedge HCLK);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (is_onehot(cur.hsel) && cur.hsel[i]) begin
          P_HREADYOUT[i]           = (dcnt >= int'(cur.waits));
          P_HRESP[i]               = cur.serr;
          P_HRDATA[i*DW +: DW]     = cur.data;
        end else begin
          P_HREADYOUT[i]           = 1'($urandom_range(0, 1));
          P_HRESP[i]               = 1'($urandom_range(0, 1));
          P_HRDATA[i*DW +: DW]     = $urandom;
        end
      end
      P_HSEL      = nxt.hsel;
      HTRANS      = nxt.trans;
      TIMEOUT_CLR = cur.clr_all ? 1'b1 : ($urandom_range(0, 3) == 0);
      @(negedge HCLK);
      b = beat_t'(exp_q.pop_front());
      if (b.terr1) begin
        m_flag = 1'b1;
        m_port = port_of(cur.hsel);
      end else if (clr_prev) begin
        m_flag = 1'b0;
      end
      clr_prev = TIMEOUT_CLR;
      chk("hreadyout",    64'(HREADYOUT),    64'(b.rdy));
      chk("hresp",        64'(HRESP),        64'(b.rsp));
      chk("hrdata",       64'(HRDATA),       64'(b.dat));
      chk("p_abort",      64'(P_ABORT),      64'(b.abrt));
      chk("timeout_flag", 64'(TIMEOUT_FLAG), 64'(m_flag));
      chk("timeout_port", 64'(TIMEOUT_PORT), 64'(m_port));
      if (b.rdy) begin
        cur  = nxt;
        push_beats(cur);
        nxt  = next_xfer();
        dcnt = 0;
      end else begin
        dcnt++;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset values.
    repeat (2) @(negedge HCLK);
    chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("rst_hresp",     64'(HRESP),     64'd0);
    chk("rst_hrdata",    64'(HRDATA),    64'd0);
    chk("rst_abort",     64'(P_ABORT),   64'd0);
    chk("rst_flag",      64'(TIMEOUT_FLAG), 64'd0);
    chk("rst_port",      64'(TIMEOUT_PORT), 64'd0);
    HRESET = 1'b0;

    // Unmapped active transfer, then reset asserted during ERR1.
    @(posedge HCLK); #1;
    P_HSEL = '0;
    HTRANS = 2'b10;
    @(negedge HCLK);
    chk("pre_err_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("pre_err_hresp",     64'(HRESP),     64'd0);
    @(posedge HCLK); #1;
    HTRANS = 2'b00;
    @(negedge HCLK);
    chk("err1_hreadyout", 64'(HREADYOUT), 64'd0);
    chk("err1_hresp",     64'(HRESP),     64'd1);
    #1 HRESET = 1'b1;
    #1;
    chk("async_rst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("async_rst_hresp",     64'(HRESP),     64'd0);
    chk("async_rst_hrdata",    64'(HRDATA),    64'd0);
    @(negedge HCLK);
    HRESET = 1'b0;

    // Directed transfers followed by random traffic.
    plan_q.push_back(mk_xfer(5'b00010, 2'b10, 1,  1'b0, 1'b0, 32'h1111_0001));
    plan_q.push_back(mk_xfer(5'b01000, 2'b10, 2,  1'b0, 1'b0, 32'hA5A5_0003));
    plan_q.push_back(mk_xfer(5'b00000, 2'b10, 0,  1'b0, 1'b0, 32'h0));
    plan_q.push_back(mk_xfer(5'b00110, 2'b10, 0,  1'b0, 1'b0, 32'h0));
    plan_q.push_back(mk_xfer(5'b00000, 2'b00, 0,  1'b0, 1'b0, 32'h0));
    plan_q.push_back(mk_xfer(5'b00110, 2'b00, 0,  1'b0, 1'b0, 32'h0));
    plan_q.push_back(mk_xfer(5'b00001, 2'b10, 0,  1'b0, 1'b0, 32'hC0DE_0000));
    plan_q.push_back(mk_xfer(5'b00000, 2'b10, 0,  1'b0, 1'b0, 32'h0));
    plan_q.push_back(mk_xfer(5'b10000, 2'b11, 1,  1'b0, 1'b0, 32'hC0DE_0004));
    plan_q.push_back(mk_xfer(5'b00100, 2'b10, 1,  1'b1, 1'b0, 32'hEEEE_0002));
    plan_q.push_back(mk_xfer(5'b00100, 2'b10, 20, 1'b0, 1'b0, 32'h2222_0002));
    plan_q.push_back(mk_xfer(5'b00000, 2'b00, 0,  1'b0, 1'b0, 32'h0));
    plan_q.push_back(mk_xfer(5'b00100, 2'b10, 20, 1'b0, 1'b1, 32'h3333_0002));
    model_init();
    run_cycles(1500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
